// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA raster timing generator:
//   - region_e     : per-axis raster region (ACTIVE, FRONT, SYNC, BACK)
//   - DEF_*        : default 640x480 @ 60 Hz timing constants
//   - calc_total() : line/frame length from the four segment widths
//   - region_of()  : region that a given counter position falls into
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } region_e;

  // Default 640x480 timing (pixels / lines)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  function automatic int calc_total(input int active_w, input int front_w,
                                    input int sync_w, input int back_w);
    return active_w + front_w + sync_w + back_w;
  endfunction

  // Region of an arbitrary position; lets a counter that does not reset to 0
  // (the lookahead counters) start with a consistent region state.
  function automatic region_e region_of(input int pos, input int active_w,
                                        input int front_w, input int sync_w);
    if (pos < active_w)                          return ACTIVE;
    else if (pos < active_w + front_w)           return FRONT;
    else if (pos < active_w + front_w + sync_w)  return SYNC;
    else                                         return BACK;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a CW-bit position counter that wraps at TOTAL-1, plus the
// ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE region state machine.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset (count -> RESET_VAL)
//   adv_i     in   advance the counter by one position this edge
//   count_o   out  current position (registered)
//   region_o  out  region the axis enters at the coming edge (next state),
//                  so the parent can register its decoded outputs in step
//                  with count_o
//   wrap_o    out  count is at TOTAL-1 (an advance now wraps to 0)
// ---------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CW        = 10,
  parameter int ACTIVE_W  = DEF_H_ACTIVE,
  parameter int FRONT_W   = DEF_H_FRONT,
  parameter int SYNC_W    = DEF_H_SYNC,
  parameter int BACK_W    = DEF_H_BACK,
  parameter int RESET_VAL = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv_i,
  output logic [CW-1:0] count_o,
  output region_e       region_o,
  output logic          wrap_o
);

  localparam int TOTAL = calc_total(ACTIVE_W, FRONT_W, SYNC_W, BACK_W);

  // Last position of each region, all held at CW bits.
  localparam logic [CW-1:0] ACT_END = CW'(ACTIVE_W - 1);
  localparam logic [CW-1:0] FRT_END = CW'(ACTIVE_W + FRONT_W - 1);
  localparam logic [CW-1:0] SYN_END = CW'(ACTIVE_W + FRONT_W + SYNC_W - 1);
  localparam logic [CW-1:0] LAST    = CW'(TOTAL - 1);

  localparam logic [CW-1:0] RST_COUNT  = CW'(RESET_VAL);
  localparam region_e       RST_REGION = region_of(RESET_VAL, ACTIVE_W, FRONT_W, SYNC_W);

  logic [CW-1:0] count_q, count_d;
  region_e       region_q, region_d;
  logic          at_last;

  assign at_last = (count_q == LAST);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= RST_COUNT;
      region_q <= RST_REGION;
    end else begin
      count_q  <= count_d;
      region_q <= region_d;
    end
  end

  // Next-state logic: the counter never produces a value >= TOTAL because it
  // is forced to 0 from LAST instead of incrementing.
  // NOTE: defaults at the top of every always_comb keep all paths assigned, so
  // no latch is inferred.
  always_comb begin
    count_d  = count_q;
    region_d = region_q;
    if (adv_i) begin
      count_d = at_last ? '0 : count_q + CW'(1);
      unique case (region_q)
        ACTIVE: if (count_q == ACT_END) region_d = FRONT;
        FRONT:  if (count_q == FRT_END) region_d = SYNC;
        SYNC:   if (count_q == SYN_END) region_d = BACK;
        BACK:   if (at_last)            region_d = ACTIVE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    count_o  = count_q;
    region_o = region_d;
    wrap_o   = at_last;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Coordinates advance only on
// pix_en, so the block can run from a fast system clock with a prescaled
// pixel rate. Every output is a flop, so x/y/hsync/vsync/de for a position
// change in the same clk cycle.
//
// Optional feature (macro VGA_TIMING_LOOKAHEAD_EN):
//   adds nx/ny, the position (x,y) will hold LEAD pix_en steps later.
//   Without the macro the lookahead counters and ports do not exist and
//   LEAD is ignored.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   pix_en       in   pixel strobe; counters advance on edges where it is high
//   x, y         out  current position
//   hsync/vsync  out  sync pulses at HS_POL / VS_POL level
//   de           out  display enable (x < H_ACTIVE and y < V_ACTIVE)
//   line_start   out  one-clk pulse when x has just wrapped to 0
//   frame_start  out  one-clk pulse when (x,y) has just wrapped to (0,0)
//   nx, ny       out  lookahead position (macro only)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int LEAD     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic [CW-1:0] nx,
  output logic [CW-1:0] ny
`endif
);

  logic    h_wrap, v_wrap, v_adv;
  region_e h_region, v_region;

  // Vertical axis moves by whole lines, on the pixel step that wraps x.
  assign v_adv = pix_en & h_wrap;

  vga_axis_counter #(
    .CW(CW), .ACTIVE_W(H_ACTIVE), .FRONT_W(H_FRONT),
    .SYNC_W(H_SYNC), .BACK_W(H_BACK), .RESET_VAL(0)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .adv_i(pix_en),
    .count_o(x), .region_o(h_region), .wrap_o(h_wrap)
  );

  vga_axis_counter #(
    .CW(CW), .ACTIVE_W(V_ACTIVE), .FRONT_W(V_FRONT),
    .SYNC_W(V_SYNC), .BACK_W(V_BACK), .RESET_VAL(0)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .adv_i(v_adv),
    .count_o(y), .region_o(v_region), .wrap_o(v_wrap)
  );

  // Decoded outputs are registered from the axes' next region so they line
  // up with the counter flops instead of trailing them by a cycle.
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  always_comb begin
    hsync_d       = (h_region == SYNC) ? HS_POL : ~HS_POL;
    vsync_d       = (v_region == SYNC) ? VS_POL : ~VS_POL;
    de_d          = (h_region == ACTIVE) && (v_region == ACTIVE);
    // Strobes come from pix_en itself, so they drop to 0 on idle cycles.
    line_start_d  = pix_en & h_wrap;
    frame_start_d = pix_en & h_wrap & v_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_LOOKAHEAD_EN
  // A second pair of axis counters started LEAD positions ahead and stepped
  // by the same pix_en; since LEAD < H_TOTAL the start point stays on line 0.
  logic    nx_wrap, ny_wrap, ny_adv;
  region_e nx_region, ny_region;

  assign ny_adv = pix_en & nx_wrap;

  vga_axis_counter #(
    .CW(CW), .ACTIVE_W(H_ACTIVE), .FRONT_W(H_FRONT),
    .SYNC_W(H_SYNC), .BACK_W(H_BACK), .RESET_VAL(LEAD)
  ) u_nx_axis (
    .clk(clk), .rst_n(rst_n), .adv_i(pix_en),
    .count_o(nx), .region_o(nx_region), .wrap_o(nx_wrap)
  );

  vga_axis_counter #(
    .CW(CW), .ACTIVE_W(V_ACTIVE), .FRONT_W(V_FRONT),
    .SYNC_W(V_SYNC), .BACK_W(V_BACK), .RESET_VAL(0)
  ) u_ny_axis (
    .clk(clk), .rst_n(rst_n), .adv_i(ny_adv),
    .count_o(ny), .region_o(ny_region), .wrap_o(ny_wrap)
  );
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Small raster (H=8/2/2/2 -> 14, V=4/1/1/1 -> 7, both syncs active-high).
// The stimulus process drives one clk cycle at a time and pushes the
// expected outputs for the following cycle into a queue; the monitor pops
// one entry per clk and compares. Hand-computed directed checks cover reset
// values, reset-with-pix_en and the frame wrap.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int CW   = 10;
  localparam int HA   = 8,  HF = 2, HS = 2, HB = 2;
  localparam int VA   = 4,  VF = 1, VS = 1, VB = 1;
  localparam int HT   = 14;   // 8+2+2+2
  localparam int VT   = 7;    // 4+1+1+1
  localparam int LEAD = 3;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pix_en;
  logic [CW-1:0] x, y;
  logic          hsync, vsync, de, line_start, frame_start;
`ifdef VGA_TIMING_LOOKAHEAD_EN
  logic [CW-1:0] nx, ny;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HS_POL(HPOL), .VS_POL(VPOL), .CW(CW), .LEAD(LEAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .de(de),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TIMING_LOOKAHEAD_EN
    , .nx(nx), .ny(ny)
`endif
  );

  typedef struct {
    int   x, y;
    logic hs, vs, de, ls, fs;
    int   nx, ny;
    bit   cont;   // part of an uninterrupted pix_en=1 run
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mx = 0, my = 0;   // model position

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic void adv(inout int px, inout int py);
    if (px == HT - 1) begin
      px = 0;
      py = (py == VT - 1) ? 0 : py + 1;
    end else begin
      px = px + 1;
    end
  endfunction

  // Drive one cycle and queue what the DUT must show after the next edge.
  task automatic step(input bit r, input bit p, input bit cont);
    exp_t e;
    int   ax, ay;
    @(negedge clk);
    rst_n  = r;
    pix_en = p;
    e.ls = 1'b0;
    e.fs = 1'b0;
    if (!r) begin
      mx = 0;
      my = 0;
    end else if (p) begin
      e.ls = (mx == HT - 1);
      e.fs = e.ls && (my == VT - 1);
      adv(mx, my);
    end
    e.x  = mx;
    e.y  = my;
    e.hs = (mx >= 10 && mx <= 11) ? HPOL : !HPOL;
    e.vs = (my == 5) ? VPOL : !VPOL;
    e.de = (mx < HA) && (my < VA);
    ax = mx;
    ay = my;
    repeat (LEAD) adv(ax, ay);
    e.nx   = ax;
    e.ny   = ay;
    e.cont = cont;
    sb.push_back(e);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    int   cyc, last_ls, last_fs;
    cyc = 0; last_ls = -1; last_fs = -1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("x",           x,           e.x);
        check("y",           y,           e.y);
        check("hsync",       hsync,       e.hs);
        check("vsync",       vsync,       e.vs);
        check("de",          de,          e.de);
        check("line_start",  line_start,  e.ls);
        check("frame_start", frame_start, e.fs);
`ifdef VGA_TIMING_LOOKAHEAD_EN
        check("nx", nx, e.nx);
        check("ny", ny, e.ny);
`endif
        if (e.cont) begin
          if (line_start === 1'b1) begin
            if (last_ls >= 0) check("line_period", cyc - last_ls, 14);
            last_ls = cyc;
          end
          if (frame_start === 1'b1) begin
            if (last_fs >= 0) check("frame_period", cyc - last_fs, 98);
            last_fs = cyc;
          end
        end else begin
          last_ls = -1;
          last_fs = -1;
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;

    // Reset, then hand-checked reset values.
    repeat (3) step(1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_de", de, 1);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_ls", line_start, 0);
`ifdef VGA_TIMING_LOOKAHEAD_EN
    check("rst_nx", nx, 3);
    check("rst_ny", ny, 0);
`endif

    // Two full frames with pix_en tied high.
    repeat (2 * 98 + 2) step(1'b1, 1'b1, 1'b1);

    // pix_en on every 4th clk: outputs hold, strobes only after a strobe edge.
    for (int i = 0; i < 120; i++) step(1'b1, (i % 4) == 3, 1'b0);

    // Reset together with pix_en in mid-frame at (5,2).
    for (int i = 0; i < 200 && !(mx == 5 && my == 2); i++) step(1'b1, 1'b1, 1'b0);
    check("pre_rst_pos", (mx == 5 && my == 2), 1);
    step(1'b0, 1'b1, 1'b0);
    @(posedge clk); #2;
    check("rstpe_x", x, 0);
    check("rstpe_y", y, 0);
    check("rstpe_de", de, 1);
    check("rstpe_hsync", hsync, 0);
    check("rstpe_vsync", vsync, 0);
    check("rstpe_ls", line_start, 0);
    check("rstpe_fs", frame_start, 0);
    repeat (3) step(1'b1, 1'b0, 1'b0);

    // Walk to (13,6) and take the frame wrap.
    for (int i = 0; i < 200 && !(mx == HT - 1 && my == VT - 1); i++)
      step(1'b1, 1'b1, 1'b0);
    check("pre_wrap_pos", (mx == 13 && my == 6), 1);
    step(1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    check("wrap_x", x, 0);
    check("wrap_y", y, 0);
    check("wrap_ls", line_start, 1);
    check("wrap_fs", frame_start, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    check("sb_drain", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the successor to our fixed 640x480 sync generator. It produces pixel coordinates, sync pulses with selectable polarity, display-enable and line/frame start strobes. Counters advance only on a pixel-enable strobe, so the block can run from a fast system clock with a prescaled pixel rate. It sits between the clock/prescaler logic and every pattern or renderer block, and drives the output pins' sync lines.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CW, 10, coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CW
- LEAD, 1, lookahead distance in pixel steps, 1 ≤ LEAD < H_TOTAL (only with macro)

- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel strobe; counters advance on clk edges where it is high
- x  out  CW  current horizontal position
- y  out  CW  current vertical position
- hsync  out  1  horizontal sync at HS_POL level
- vsync  out  1  vertical sync at VS_POL level
- de  out  1  high when x < H_ACTIVE and y < V_ACTIVE
- line_start  out  1  one-clk pulse when x wraps to 0
- frame_start  out  1  one-clk pulse when x and y both wrap to 0
- nx, ny  out  CW each  lookahead coordinates (only with macro)

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK. V_TOTAL is formed the same way.
- Each axis has a region state machine: ACTIVE → FRONT → SYNC → BACK → ACTIVE. The state changes when the axis counter crosses each boundary: H_ACTIVE, +H_FRONT, +H_SYNC, and wrap at TOTAL-1.
- On pix_en: x increments. At x = H_TOTAL-1, x goes to 0.
- The vertical axis advances only on pix_en with the horizontal wrap. At y = V_TOTAL-1 with the horizontal wrap, y goes to 0.
- hsync is active exactly while the horizontal region is SYNC. vsync is active exactly while the vertical region is SYNC. This is vertical sync by whole lines, changing at the horizontal wrap.
- Width rule: counters are CW bits. Compares are done at CW bits, and no counter value ≥ TOTAL is ever produced.
- With pix_en low, every output holds, except that line_start and frame_start are forced to 0.

## Timing
- All outputs are registered. x, y, hsync, vsync and de for a given position appear in the same cycle, with zero skew between them.
- Latency: the outputs reflect the new position in the clk cycle after the edge that sampled pix_en high.
- line_start is high for exactly one clk, in the cycle where x has just become 0. frame_start is high only in the cycle where (x,y) has just become (0,0).
- Reset values (synchronous, any time including mid-frame): x=0, y=0, de=1, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0. Both region states reset to ACTIVE.
- Reset asserted together with pix_en: reset wins, and no strobe is emitted.
- The first frame_start after reset occurs on the wrap from (H_TOTAL-1, V_TOTAL-1).

## Configuration
- VGA_TIMING_LOOKAHEAD_EN defined: adds the nx and ny ports.
  - (nx, ny) equals the position that (x, y) will hold LEAD pix_en steps later, including wrap across lines and frames.
  - Reset value is the position LEAD steps after (0,0).
  - nx and ny advance and hold exactly as x and y do.
- Not defined: nx, ny and the lookahead counters are absent, and the LEAD parameter is unused.

## Structure
- Package vga_timing_pkg holds:
  - the region enum typedef (ACTIVE, FRONT, SYNC, BACK);
  - the default 640x480 timing constants;
  - a function computing TOTAL from the four segment widths.
- Sub-module vga_axis_counter is instantiated once per axis, and twice more for lookahead.
  - Inputs: advance enable, rst_n.
  - Outputs: count, region, wrap flag.
  - The horizontal wrap flag gates the vertical advance enable.

## Test plan
- Default params, pix_en tied to 1, run 2 frames:
  - every line is 800 clks and every frame is 420000 clks;
  - hsync is low for x = 656..751;
  - vsync is low for y = 490..491;
  - de is high for 307200 clks per frame.
- Small params H=8/2/2/2, V=4/1/1/1, HS_POL=VS_POL=1:
  - line_start every 14 clks;
  - frame_start every 98 clks;
  - hsync high at x = 10..11.
- pix_en every 4th clk: all outputs hold between strobes. line_start is 1 clk wide and is emitted only after the wrapping strobe.
- Assert rst_n=0 at (x=300, y=200) together with pix_en=1. Next cycle shows x=0, y=0, de=1, syncs inactive, and no strobe.
- Position (H_TOTAL-1, V_TOTAL-1) with pix_en: the next cycle shows x=0, y=0, line_start=1, frame_start=1.
- With the macro and LEAD=3: nx equals x+3 mod H_TOTAL on every cycle. At x=H_TOTAL-2, ny has already advanced to y+1. After reset, (nx, ny) = (3, 0).
